// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multu sequencer state encoding and funct codes
// used by decode and the multiply unit.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } multu_state_t;

  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

endpackage

// File: rtl/multu_dp.sv
// Radix-2 shift-add multiply datapath with HI/LO commit registers.
// Optional early termination under MULTU_EARLY_TERM_EN.
module multu_dp
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             commit,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [CNT_W-1:0] cnt,
  output logic             last_c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH + 1;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_step;
  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0] prod;

  // One iteration: conditional add into the upper half, then shift right.
  always_comb begin
    acc_sum = acc[ACC_W-1:WIDTH];
    if (mplier[0]) begin
      acc_sum = acc[ACC_W-1:WIDTH] + (WIDTH+1)'(mcand);
    end
    acc_step = {acc_sum, acc[WIDTH-1:0]} >> 1;
  end

`ifdef MULTU_EARLY_TERM_EN
  logic [CNT_W-1:0] align_sh;

  // Once the remaining multiplier bits are zero, apply the leftover shifts at once.
  assign align_sh = CNT_W'(WIDTH - 1) - cnt;
  assign last_c   = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
  assign prod     = (2*WIDTH)'(acc_step >> align_sh);
`else
  assign last_c   = (cnt == CNT_W'(WIDTH - 1));
  assign prod     = (2*WIDTH)'(acc_step);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (step) begin
      mplier <= mplier >> 1;
      acc    <= acc_step;
    end
  end

  // HI/LO hold the previous product until the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= prod[2*WIDTH-1:WIDTH];
      lo <= prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multu_seq_ctl.sv
// Sequencing controller for multu: FSM, iteration counter and mfhi/mflo stall.
// Build option MULTU_EARLY_TERM_EN enables early termination in multu_dp.
module multu_seq_ctl
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  multu_state_t     state;
  multu_state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             commit;
  logic             last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start is only honoured outside BUSY; a busy start is held off by stall.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BUSY:  if (last_c) state_nxt = S_DONE;
      default: state_nxt = start ? S_BUSY : S_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    unique case (state)
      S_BUSY: begin
        step   = 1'b1;
        commit = last_c;
      end
      default: load = start;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign busy  = (state == S_BUSY);
  assign done  = (state == S_DONE);
  assign stall = (rd_hi | rd_lo | start) & busy;

  multu_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .commit (commit),
    .op_a   (op_a),
    .op_b   (op_b),
    .cnt    (cnt),
    .last_c (last_c),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_multu_seq_ctl.sv
// Self-checking bench for multu_seq_ctl: vector table, random operands against
// a 64-bit arithmetic model, and hand-written stall/reset/back-to-back sequences.
module tb_multu_seq_ctl;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] prev    = '0;

  always #5 clk = ~clk;

  multu_seq_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .rd_hi (rd_hi),
    .rd_lo (rd_lo),
    .busy  (busy),
    .done  (done),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected cycles from accepted start to commit.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MULTU_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h + 1;
`else
    return 32;
`endif
  endfunction

  // Issue at a negedge while IDLE/DONE; returns at the negedge of the DONE cycle.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input bit hold_rd, input bit busy_start);
    int lat;
    int cycles;
    bit hold_ok;
    bit stall_ok;
    lat   = exp_lat(b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    rd_hi = hold_rd;
    #1 check("stall_at_issue", 64'(stall), 64'd0);
    @(negedge clk);
    start    = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    cycles   = 0;
    hold_ok  = 1'b1;
    stall_ok = 1'b1;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if ({hi, lo} !== prev) hold_ok = 1'b0;
      start = busy_start && (cycles == 3 || cycles == 4);
      #1 if (stall !== (hold_rd || start)) stall_ok = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", 64'(cycles), 64'(lat));
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("stall_in_done", 64'(stall), 64'd0);
    check("hi", 64'(hi), 64'(exp[63:32]));
    check("lo", 64'(lo), 64'(exp[31:0]));
    check("hilo_hold_during_busy", 64'(hold_ok), 64'd1);
    check("stall_during_busy", 64'(stall_ok), 64'd1);
    rd_hi = 1'b0;
    prev  = exp;
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd3,          32'd5,          32'd0,          32'd15};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001};
    vecs[2] = '{32'd7,          32'd9,          32'd0,          32'd63};
    vecs[3] = '{32'h1234_5678,  32'd0,          32'd0,          32'd0};
    vecs[4] = '{32'd0,          32'hDEAD_BEEF,  32'd0,          32'd0};
    vecs[5] = '{32'h8000_0000,  32'd2,          32'd1,          32'd0};
    vecs[6] = '{32'd1,          32'h8000_0000,  32'd0,          32'h8000_0000};
    vecs[7] = '{32'h0001_0000,  32'h0001_0000,  32'd1,          32'd0};

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo}, 1'b0, 1'b0);
      idle_cycle();
    end

    // Back-to-back: second start in the DONE cycle
    run_mul(32'd3, 32'd5, 64'd15, 1'b0, 1'b0);
    run_mul(32'd7, 32'd9, 64'd63, 1'b0, 1'b0);
    idle_cycle();

    // Start while busy is ignored and stalled
    run_mul(32'h0002_0000, 32'h0003_0000, 64'h6_0000_0000, 1'b0, 1'b1);
    idle_cycle();

    // mfhi held during the multiply
    run_mul(32'h0001_0000, 32'h0003_0000, 64'h3_0000_0000, 1'b1, 1'b0);
    idle_cycle();

    // Random operands against the arithmetic model, alternating back-to-back
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_mul(ra, rb, 64'(ra) * 64'(rb), 1'b0, 1'b0);
      if (k % 2 == 1) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset mid-iteration
    start = 1'b1;
    op_a  = 32'h0000_FFFF;
    op_b  = 32'h8000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    prev = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    run_mul(32'd3, 32'd5, 64'd15, 1'b0, 1'b0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
